// File: rtl/data_mem_responder_pkg.sv
// Shared data-segment constants and fill-FSM encoding for the data-memory responder.
// The base/size constants are the same ones the datapath address decode uses.
package data_mem_responder_pkg;

    localparam logic [31:0] DATA_SEG_BASE  = 32'h1001_0000;
    localparam int unsigned DATA_SEG_WORDS = 1024;
    localparam int unsigned DATA_SEG_BYTES = 4 * DATA_SEG_WORDS;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } fill_state_e;

endpackage

// File: rtl/data_mem_responder_ram_be_sp.sv
// Single-port word RAM with four byte-lane write enables and a registered output.
// The output register captures the pre-write contents when read and write hit the same word.
module data_mem_responder_ram_be_sp #(
    parameter int unsigned Depth     = 1024,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic [AddrWidth-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           we,
    input  logic                 re,
    output logic [31:0]          rdata
);

    logic [31:0] mem [Depth];

    // No reset: keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        for (int n = 0; n < 4; n++) begin
            if (we[n]) begin
                mem[addr][8*n +: 8] <= wdata[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory bus slave: window decode, post-reset zero fill, byte-lane writes,
// 1-cycle registered reads and an out-of-window error pulse with captured address.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DATA_SEG_BASE,
    parameter int unsigned DEPTH_WORDS    = DATA_SEG_WORDS,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic        iWriteEnable,
    input  logic        iReadEnable,
    input  logic [3:0]  iByteEnable,
    output logic [31:0] oReadData,
    output logic        oReady,
    output logic        oError,
    output logic [31:0] oErrAddr
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH_WORDS - 1);

    fill_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          fill_we;

    logic          hit;
    logic          borrow;
    logic [AW-1:0] bus_idx;
    logic          ready;
    logic          bus_acc;
    logic          bus_miss;
    logic          bus_rd;
    logic          bus_wr;

    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    logic          rd_zero_q;
    logic          err_q;
    logic [31:0]   err_addr_q;

    // Window decode in 33 bits so a window ending at the top of the map cannot wrap.
    assign hit = ({1'b0, iAddress} >= {1'b0, BASE_ADDR}) && ({1'b0, iAddress} < END_ADDR);

    // Word index of (iAddress - BASE_ADDR), with the borrow out of the ignored byte bits.
    assign borrow  = iAddress[1:0] < BASE_ADDR[1:0];
    assign bus_idx = iAddress[AW+1:2] - BASE_ADDR[AW+1:2] - AW'(borrow);

    assign ready    = (state_q == StReady);
    assign bus_acc  = ready && (iWriteEnable || iReadEnable);
    assign bus_miss = bus_acc && !hit;
    assign bus_rd   = ready && iReadEnable && hit;
    assign bus_wr   = ready && iWriteEnable && hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_we = 1'b0;
        unique case (state_q)
            StClear: begin
                if (CLEAR_ON_RESET) begin
                    fill_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = StReady;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    always_comb begin
        ram_addr  = bus_idx;
        ram_wdata = iWriteData;
        ram_we    = bus_wr ? iByteEnable : 4'b0000;
        if (fill_we) begin
            ram_addr  = cnt_q;
            ram_wdata = '0;
            ram_we    = 4'b1111;
        end
    end

    data_mem_responder_ram_be_sp #(
        .Depth     (DEPTH_WORDS),
        .AddrWidth (AW)
    ) u_ram (
        .clk   (iCLK),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .we    (ram_we),
        .re    (bus_rd),
        .rdata (ram_rdata)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= StClear;
            cnt_q      <= '0;
            rd_zero_q  <= 1'b1;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= bus_miss;
            if (bus_miss) begin
                err_addr_q <= iAddress;
                rd_zero_q  <= 1'b1;
            end else if (bus_rd) begin
                rd_zero_q <= 1'b0;
            end
        end
    end

    // The RAM output register is unreset and holds between reads; mask it after reset or a miss.
    assign oReadData = rd_zero_q ? 32'h0 : ram_rdata;
    assign oReady    = ready;
    assign oError    = err_q;
    assign oErrAddr  = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: behavioural memory model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  be    = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [31:0] erraddr;

    data_mem_responder #(
        .BASE_ADDR      (BASE),
        .DEPTH_WORDS    (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iAddress     (addr),
        .iWriteData   (wdata),
        .iWriteEnable (we),
        .iReadEnable  (re),
        .iByteEnable  (be),
        .oReadData    (rdata),
        .oReady       (ready),
        .oError       (err),
        .oErrAddr     (erraddr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_fill;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_erraddr;

    function automatic bit in_win(input logic [31:0] a);
        logic [63:0] x = {32'h0, a};
        logic [63:0] b = {32'h0, BASE};
        return (x >= b) && (x < b + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return int'(off >> 2);
    endfunction

    // Fill takes DEPTH cycles after reset; once complete every word is zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill    <= 0;
            m_rdata   <= '0;
            m_err     <= 1'b0;
            m_erraddr <= '0;
        end else if (m_fill < DEPTH) begin
            m_fill <= m_fill + 1;
            m_err  <= 1'b0;
            if (m_fill == DEPTH - 1) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            end
        end else begin
            m_err <= 1'b0;
            if ((we || re) && !in_win(addr)) begin
                m_err     <= 1'b1;
                m_erraddr <= addr;
                m_rdata   <= '0;
            end else if (we || re) begin
                if (re) m_rdata <= m_mem[widx(addr)];
                if (we) begin
                    for (int n = 0; n < 4; n++) begin
                        if (be[n]) m_mem[widx(addr)][8*n +: 8] <= wdata[8*n +: 8];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_ready", {31'b0, ready}, {31'b0, m_fill == DEPTH});
        check("model_error", {31'b0, err}, {31'b0, m_err});
        check("model_erraddr", erraddr, m_erraddr);
        check("model_rdata", rdata, m_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        we = w; re = r; addr = a; wdata = d; be = b;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; re = 1'b0; be = 4'b0000;
    endtask

    task automatic wait_ready(input string name);
        int c = 0;
        while (!ready && c < 100) begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check(name, 32'(c), 32'(DEPTH));
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, BASE + 32'(4 * i), '0, 4'b0000);
            check(name, rdata, 32'h0);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_error", {31'b0, err}, 32'h0);
        check("rst_erraddr", erraddr, 32'h0);

        // 1: fill timing and contents
        rst = 1'b0;
        wait_ready("fill_cycles");
        read_all_zero("fill_zero");

        // 2: full-word write then read
        access(1'b1, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF, 4'b1111);
        access(1'b0, 1'b1, BASE + 32'd8, '0, 4'b0000);
        check("word_rd", rdata, 32'hDEAD_BEEF);

        // 3: single-lane write merges into the old word
        access(1'b1, 1'b0, BASE + 32'd8, 32'h0000_AA00, 4'b0010);
        access(1'b0, 1'b1, BASE + 32'd8, '0, 4'b0000);
        check("lane_rd", rdata, 32'hDEAD_AAEF);

        // 4: read-before-write on the same word
        access(1'b1, 1'b0, BASE + 32'd4, 32'h1111_1111, 4'b1111);
        access(1'b1, 1'b1, BASE + 32'd4, 32'h2222_2222, 4'b1111);
        check("rbw_old", rdata, 32'h1111_1111);
        access(1'b0, 1'b1, BASE + 32'd4, '0, 4'b0000);
        check("rbw_new", rdata, 32'h2222_2222);

        // 5: out-of-window accesses on both sides
        access(1'b0, 1'b1, BASE - 32'd4, '0, 4'b0000);
        check("miss_lo_err", {31'b0, err}, 32'h1);
        check("miss_lo_addr", erraddr, BASE - 32'd4);
        check("miss_lo_rdata", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("miss_pulse_end", {31'b0, err}, 32'h0);
        check("miss_addr_hold", erraddr, BASE - 32'd4);
        access(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'b1111);
        check("miss_hi_err", {31'b0, err}, 32'h1);
        check("miss_hi_addr", erraddr, BASE + 32'(4 * DEPTH));
        access(1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), '0, 4'b0000);
        check("miss_no_write", rdata, 32'h0);
        access(1'b0, 1'b1, BASE + 32'd4, '0, 4'b0000);
        check("miss_keep_word", rdata, 32'h2222_2222);

        // Zero byte-enable write is a no-op; low address bits are ignored.
        access(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'b0000);
        check("be0_noerr", {31'b0, err}, 32'h0);
        access(1'b0, 1'b1, BASE + 32'd9, '0, 4'b0000);
        check("be0_unchanged", rdata, 32'hDEAD_AAEF);

        // 6: reset mid-fill restarts the fill from word 0
        access(1'b1, 1'b0, BASE + 32'd12, 32'h5, 4'b1111);
        access(1'b0, 1'b1, BASE + 32'd12, '0, 4'b0000);
        check("pre_reset_word", rdata, 32'h5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        access(1'b1, 1'b0, BASE - 32'd4, 32'h7, 4'b1111);
        check("clear_ignore_err", {31'b0, err}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("midfill_ready", {31'b0, ready}, 32'h0);
        rst = 1'b0;
        wait_ready("refill_cycles");
        read_all_zero("refill_zero");

        // Randomized traffic with occasional resets
        repeat (600) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 19);
            if (sel < 16) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (sel < 18) a = BASE - 32'(4 * $urandom_range(1, 4));
            else a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                       $urandom, 4'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
